// File: rtl/bcd_display_scan.sv
// Time-multiplexed 7-segment scanner for packed BCD words, double-buffered so a
// new value only reaches the display at a scan-frame boundary (no tearing).
module bcd_display_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    bcd_valid,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = 5 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  // Buffers hold {dp bits, packed BCD}; dp bits sit above the BCD nibbles.
  logic [CW-1:0]         cnt_p0;
  logic [IW-1:0]         idx_p0;
  logic                  tick_p0;
  logic                  wrap_p0;
  logic [BW-1:0]         pend_reg;
  logic [BW-1:0]         disp_reg;
  logic                  pending;
  logic                  run_p1;
  logic [3:0]            cur_bcd_p0;
  logic                  cur_dp_p0;
  logic                  lz_run;
  logic [NUM_DIGITS-1:0] lead_zero_p0;
  logic                  blank_p0;
  logic [NUM_DIGITS-1:0] an_nxt_p0;
  logic [6:0]            seg_nxt_p0;

  // Active-high gfedcba pattern; non-decimal codes show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Stage p0: refresh prescaler and digit index
  always_comb begin
    tick_p0 = (cnt_p0 == CNT_MAX);
    wrap_p0 = tick_p0 && (idx_p0 == IDX_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0     <= '0;
      idx_p0     <= '0;
      frame_done <= 1'b0;
    end else begin
      cnt_p0     <= tick_p0 ? '0 : cnt_p0 + 1'b1;
      if (tick_p0)
        idx_p0 <= wrap_p0 ? '0 : idx_p0 + 1'b1;
      frame_done <= wrap_p0;
    end
  end

  // Capture overrides the commit's clear of pending, so a strobe on the commit
  // edge lands in pend_reg while disp_reg takes the older buffered value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg <= '0;
      disp_reg <= '0;
      pending  <= 1'b0;
    end else begin
      if (wrap_p0 && pending) begin
        disp_reg <= pend_reg;
        pending  <= 1'b0;
      end
      if (bcd_valid) begin
        pend_reg <= {dp_in, bcd_in};
        pending  <= 1'b1;
      end
    end
  end

  always_comb begin
    lz_run       = 1'b1;
    lead_zero_p0 = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run          = lz_run && (disp_reg[4*i +: 4] == 4'd0);
      lead_zero_p0[i] = lz_run;
    end
  end

  always_comb begin
    cur_bcd_p0 = disp_reg[4*int'(idx_p0) +: 4];
    cur_dp_p0  = disp_reg[4*NUM_DIGITS + int'(idx_p0)];
    blank_p0   = BLANK_LZ && (idx_p0 != '0) && lead_zero_p0[idx_p0];
    an_nxt_p0  = '1;
    an_nxt_p0[idx_p0] = 1'b0;
    seg_nxt_p0 = blank_p0 ? 7'h7F : ~seg_decode(cur_bcd_p0);
  end

  // Stage p1: registered display drive; run_p1 keeps everything dark for the
  // first edge after reset so digit 0 lights on the second edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_p1 <= 1'b0;
      an     <= '1;
      seg    <= 7'h7F;
      dp     <= 1'b1;
    end else begin
      run_p1 <= 1'b1;
      an     <= run_p1 ? an_nxt_p0  : '1;
      seg    <= run_p1 ? seg_nxt_p0 : 7'h7F;
      dp     <= run_p1 ? ~cur_dp_p0 : 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan: loads are queued as expected frames and
// compared digit by digit on the frame that follows each frame_done.
module tb_bcd_display_scan;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [15:0]   bcd_in = '0;
  logic [3:0]    dp_in = '0;
  logic          bcd_valid = 1'b0;
  logic [3:0]    an, an0;
  logic [6:0]    seg, seg0;
  logic          dp, dp0, fd, fd0;

  always #5 clk = ~clk;

  bcd_display_scan #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .dp_in(dp_in), .bcd_valid(bcd_valid),
    .an(an), .seg(seg), .dp(dp), .frame_done(fd));

  bcd_display_scan #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .dp_in(dp_in), .bcd_valid(bcd_valid),
    .an(an0), .seg(seg0), .dp(dp0), .frame_done(fd0));

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dpv;
  } frame_t;

  frame_t sbq[$];
  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0: c = 7'h3F;  4'd1: c = 7'h06;  4'd2: c = 7'h5B;  4'd3: c = 7'h4F;
      4'd4: c = 7'h66;  4'd5: c = 7'h6D;  4'd6: c = 7'h7D;  4'd7: c = 7'h07;
      4'd8: c = 7'h7F;  4'd9: c = 7'h6F;  default: c = 7'h40;
    endcase
    return c;
  endfunction

  function automatic logic [6:0] exp_seg(input frame_t f, input int d, input bit blz);
    bit allz = 1'b1;
    for (int j = d; j < N; j++)
      if (f.bcd[4*j +: 4] != 4'd0) allz = 1'b0;
    if (blz && d > 0 && allz) return 7'h7F;
    return ~ref_code(f.bcd[4*d +: 4]);
  endfunction

  task automatic push_frame(input logic [15:0] b, input logic [3:0] p);
    frame_t f;
    f.bcd = b;
    f.dpv = p;
    sbq.push_back(f);
  endtask

  // Called at a negedge; the strobe is seen by exactly one rising edge.
  task automatic load(input logic [15:0] b, input logic [3:0] p);
    bcd_in    = b;
    dp_in     = p;
    bcd_valid = 1'b1;
    @(negedge clk);
    bcd_valid = 1'b0;
  endtask

  task automatic wait_fd(input string tag);
    int n = 0;
    while (fd !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (fd !== 1'b1) chk({tag, "_fd_timeout"}, fd, 1);
  endtask

  task automatic check_next_frame(input string tag);
    frame_t     f;
    logic [3:0] e_an;
    logic       e_dp;
    f = sbq.pop_front();
    wait_fd(tag);
    repeat (2) @(negedge clk);
    for (int d = 0; d < N; d++) begin
      if (d > 0) repeat (DIV) @(negedge clk);
      e_an    = 4'hF;
      e_an[d] = 1'b0;
      e_dp    = ~f.dpv[d];
      chk($sformatf("%s_an%0d", tag, d), an, e_an);
      chk($sformatf("%s_seg%0d", tag, d), seg, exp_seg(f, d, 1'b1));
      chk($sformatf("%s_dp%0d", tag, d), dp, e_dp);
      chk($sformatf("%s_an%0d_nolz", tag, d), an0, e_an);
      chk($sformatf("%s_seg%0d_nolz", tag, d), seg0, exp_seg(f, d, 1'b0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nfd;
    int nfd0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_fd", fd, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_edge_dark", an, 4'hF);
    @(posedge clk); #1;
    chk("second_edge_lit", an, 4'hE);

    // Idle display after reset
    push_frame(16'h0000, 4'h0);
    check_next_frame("idle");

    // Mid-frame load must not disturb the frame in progress
    wait_fd("t2sync");
    @(negedge clk);
    load(16'h1234, 4'b0010);
    chk("t2_hold_an", an, 4'hE);
    chk("t2_hold_seg", seg, 7'h40);
    push_frame(16'h1234, 4'b0010);
    check_next_frame("t2");

    load(16'h0050, 4'b0000);
    push_frame(16'h0050, 4'b0000);
    check_next_frame("t3");

    load(16'h00A0, 4'b1001);
    push_frame(16'h00A0, 4'b1001);
    check_next_frame("t4");

    // 2222 buffered, then 1111 strobed on the commit edge itself
    load(16'h2222, 4'b0000);
    load(16'h1111, 4'b0000);
    push_frame(16'h2222, 4'b0000);
    push_frame(16'h1111, 4'b0000);
    check_next_frame("t5a");
    check_next_frame("t5b");
    nfd  = 0;
    nfd0 = 0;
    repeat (16) begin
      @(negedge clk);
      if (fd)  nfd++;
      if (fd0) nfd0++;
    end
    chk("t5_fd_per_frame", nfd, 1);
    chk("t5_fd_per_frame_nolz", nfd0, 1);

    // Async reset with a capture still pending
    load(16'h9999, 4'hF);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_an", an, 4'hF);
    chk("t6_rst_seg", seg, 7'h7F);
    chk("t6_rst_dp", dp, 1'b1);
    chk("t6_rst_fd", fd, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_frame(16'h0000, 4'h0);
    check_next_frame("t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
